// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: width helper, default sizes, FSM encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package reg_bank_arbiter_pkg;

    // Ceiling log2, usable in parameter expressions; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Default sizing; the modules recompute their own widths from their parameters.
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = clog2(NREQ_DEF);

    // Bank ownership: nobody granted, or exactly one owner granted.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } st_t;

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester at or above ptr (with wrap) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the winner.
module reg_bank_arbiter_rr_pick
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDW-1:0]  win_idx,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic [IDW:0]    sum;

    // Rotate the request vector so the requester at ptr lands on bit 0.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
    end

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        any = 1'b0;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                off = IDW'(i);
            end
        end
    end

    // Undo the rotation: winner index is (ptr + off) mod NREQ.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW + 1)'(NREQ)) begin
            sum = sum - (IDW + 1)'(NREQ);
        end
        win_idx = sum[IDW-1:0];
        win_oh  = any ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one DEPTH x NUM register bank among NREQ requesters with round-robin grants and bounded locking.
// Latency: req in cycle t -> gnt in t+1; write lands at the end of the grant cycle, read data one cycle after ack.
// Backpressure: a requester waits (req held) until granted; ack = gnt & req marks the completed access.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int  NUM      = 16,
    parameter int  NREQ     = 4,
    parameter int  DEPTH    = 8,
    parameter int  AW       = 3,
    parameter int  MAX_HOLD = 4,
    localparam int IDW      = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*NUM-1:0]  wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [NUM-1:0]       rdata,
    output logic                 rvalid,
    output logic [IDW-1:0]       rid
);

    localparam int            HW        = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    // Next round-robin start: one past the given index, wrapping at NREQ.
    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
        logic [IDW-1:0] r;
        if (v == IDW'(NREQ - 1)) begin
            r = '0;
        end else begin
            r = v + IDW'(1);
        end
        return r;
    endfunction

    st_t             st_q, st_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    logic            keep;
    logic            acc;
    logic            acc_we;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [NUM-1:0]  wdata_a [NREQ];
    logic [NUM-1:0]  bank    [DEPTH];

    // Split the flattened per-requester buses into indexable arrays.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*NUM +: NUM];
    end

    reg_bank_arbiter_rr_pick #(
        .NREQ    (NREQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // The owner only accesses the bank in cycles where it still requests.
    assign gnt    = gnt_q;
    assign ack    = gnt_q & req;
    assign acc    = |ack;
    assign acc_we = |(ack & we);

    // Owner keeps the bank while it locks and has budget left; otherwise everyone re-arbitrates.
    always_comb begin
        st_d    = st_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        keep    = (st_q == ST_OWNED) && (|(gnt_q & req & lock)) && (hold_q < HOLD_LAST);
        if (keep) begin
            hold_d = hold_q + HW'(1);
        end else if (pick_any) begin
            st_d    = ST_OWNED;
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            ptr_d   = inc_wrap(pick_idx);
            hold_d  = '0;
        end else begin
            st_d   = ST_IDLE;
            gnt_d  = '0;
            hold_d = '0;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            st_q    <= st_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Bank access for the acknowledged owner; read results are registered with their requester id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            rdata  <= '0;
            rvalid <= 1'b0;
            rid    <= '0;
        end else begin
            rvalid <= 1'b0;
            if (acc) begin
                if (acc_we) begin
                    bank[addr_a[owner_q]] <= wdata_a[owner_q];
                end else begin
                    rdata  <= bank[addr_a[owner_q]];
                    rid    <= owner_q;
                    rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, round-robin, write/read, locking, drop, sole-lock, mid-burst reset.
// Latency: outputs sampled 1 time unit after each rising edge; ack sampled after inputs settle.
// Backpressure: requests are held by the bench until their expected grant cycle.
module tb_reg_bank_arbiter;

    localparam int NUM      = 16;
    localparam int NREQ     = 4;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int MAX_HOLD = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ-1:0]     we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*NUM-1:0] wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [NUM-1:0]      rdata;
    logic                rvalid;
    logic [1:0]          rid;

    int checks = 0;
    int errors = 0;

    reg_bank_arbiter #(
        .NUM      (NUM),
        .NREQ     (NREQ),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rid    (rid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [AW-1:0] a, input logic [NUM-1:0] d);
        req[i]             = r;
        lock[i]            = l;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*NUM +: NUM] = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        checks++; if (rid !== 2'd0) begin errors++; $display("FAIL reset_rid: got %0d expected 0", rid); end
        cyc();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp = 4'b0001 << (i % 4);
            checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", i, gnt, exp); end
            checks++; if (ack !== exp) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", i, ack, exp); end
            if (i > 0) begin
                checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rr_rvalid%0d: got %b expected 1", i, rvalid); end
                checks++; if (rid !== 2'(i - 1)) begin errors++; $display("FAIL rr_rid%0d: got %0d expected %0d", i, rid, i - 1); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd3, 16'hA5A5);
        cyc();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt0: got %b expected 0001", gnt); end
        set_port(2, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000);
        #1;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wr_ack0: got %b expected 0001", ack); end
        cyc();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt2: got %b expected 0100", gnt); end
        set_port(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        #1;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL wr_ack2: got %b expected 0100", ack); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", rvalid); end
        cyc();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL wr_rvalid: got %b expected 1", rvalid); end
        checks++; if (rdata !== 16'hA5A5) begin errors++; $display("FAIL wr_rdata: got %h expected a5a5", rdata); end
        checks++; if (rid !== 2'd2) begin errors++; $display("FAIL wr_rid: got %0d expected 2", rid); end
        idle_inputs();
        cyc();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_release: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid_end: got %b expected 0", rvalid); end
    endtask

    task automatic test_lock_limit();
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        we   = 4'b0010;
        set_port(3, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt%0d: got %b expected 0010", k, gnt); end
            set_port(1, 1'b1, 1'b1, 1'b1, 3'(k), 16'h1100 + 16'(k));
            #1;
            checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL lock_ack%0d: got %b expected 0010", k, ack); end
        end
        cyc();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lock_rotate: got %b expected 1000", gnt); end
        set_port(1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (rdata !== 16'h1100 + 16'(k)) begin errors++; $display("FAIL lock_data%0d: got %h expected %h", k, rdata, 16'h1100 + 16'(k)); end
            checks++; if (rvalid !== 1'b1 || rid !== 2'd3) begin errors++; $display("FAIL lock_rd%0d: got rvalid=%b rid=%0d expected rvalid=1 rid=3", k, rvalid, rid); end
            set_port(3, 1'b1, 1'b0, 1'b0, 3'(k + 1), 16'h0000);
        end
        idle_inputs();
    endtask

    task automatic test_drop();
        do_reset();
        set_port(0, 1'b1, 1'b0, 1'b1, 3'd5, 16'h1234);
        cyc();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt0: got %b expected 0001", gnt); end
        set_port(0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234);
        set_port(1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000);
        #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL drop_ack: got %b expected 0000", ack); end
        cyc();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL drop_rvalid: got %b expected 0", rvalid); end
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_next: got %b expected 0010", gnt); end
        #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL drop_ack1: got %b expected 0010", ack); end
        cyc();
        checks++; if (rvalid !== 1'b1 || rid !== 2'd1) begin errors++; $display("FAIL drop_rd: got rvalid=%b rid=%0d expected rvalid=1 rid=1", rvalid, rid); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL drop_bank: got %h expected 0000", rdata); end
        idle_inputs();
        cyc();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_idle: got %b expected 0000", gnt); end
    endtask

    task automatic test_sole_lock();
        do_reset();
        set_port(0, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sole_gnt%0d: got %b expected 0001", k, gnt); end
            set_port(0, 1'b1, 1'b1, 1'b1, 3'(k), 16'h2000 + 16'(k));
            #1;
            checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL sole_ack%0d: got %b expected 0001", k, ack); end
        end
        cyc();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sole_gnt_tail: got %b expected 0001", gnt); end
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000);
        cyc();
        checks++; if (rvalid !== 1'b1 || rid !== 2'd0) begin errors++; $display("FAIL sole_rd: got rvalid=%b rid=%0d expected rvalid=1 rid=0", rvalid, rid); end
        checks++; if (rdata !== 16'h2009) begin errors++; $display("FAIL sole_data: got %h expected 2009", rdata); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_port(1, 1'b1, 1'b1, 1'b1, 3'd5, 16'hCAFE);
        cyc();
        cyc();
        we[1] = 1'b0;
        cyc();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt: got %b expected 0010", gnt); end
        checks++; if (rvalid !== 1'b1 || rdata !== 16'hCAFE) begin errors++; $display("FAIL mid_rd: got rvalid=%b rdata=%h expected rvalid=1 rdata=cafe", rvalid, rdata); end
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 16'h0000 || rid !== 2'd0) begin errors++; $display("FAIL mid_rst_rdata: got rdata=%h rid=%0d expected 0000 0", rdata, rid); end
        idle_inputs();
        cyc();
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000);
        cyc();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_post_gnt: got %b expected 0001", gnt); end
        cyc();
        checks++; if (rvalid !== 1'b1 || rid !== 2'd0) begin errors++; $display("FAIL mid_post_rd: got rvalid=%b rid=%0d expected rvalid=1 rid=0", rvalid, rid); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL mid_post_data: got %h expected 0000", rdata); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_limit();
        test_drop();
        test_sole_lock();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
